// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The converter drives busy/done/bcd; the requester drives start/bin.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;

   modport master (
      output start,
      output bin,
      input  busy,
      input  done,
      input  bcd
   );

   modport slave (
      input  start,
      input  bin,
      output busy,
      output done,
      output bcd
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// One shift per clock; all BCD digits are presented together with a
// one-cycle done strobe, WIDTH+1 cycles after an accepted start.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   bin_to_bcd_seq_if.slave  bus
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_shift;
   logic [BW-1:0]     r_scratch;
   logic [CW-1:0]     r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [BW-1:0]     r_bcd;

   state_t            w_state_nxt;
   logic [WIDTH-1:0]  w_shift_nxt;
   logic [BW-1:0]     w_scratch_nxt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [BW-1:0]     w_bcd_nxt;
   logic [BW-1:0]     w_adj;

   // Add 3 to every digit that is 5 or more; each digit wraps within 4 bits.
   function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = s[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Next-state and datapath: load in IDLE, add-3 then shift in SHIFT.
   // The result register is loaded on the last shift so it is already
   // valid during the DONE cycle and never exposes partial scratch.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_cnt_nxt     = r_cnt;
      w_bcd_nxt     = r_bcd;
      w_adj         = add3_digits(r_scratch);
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt   = S_SHIFT;
               w_shift_nxt   = bus.bin;
               w_scratch_nxt = '0;
               w_cnt_nxt     = CW'(WIDTH);
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         S_SHIFT: begin
            w_scratch_nxt = {w_adj[BW-2:0], r_shift[WIDTH-1]};
            w_shift_nxt   = r_shift << 1;
            w_cnt_nxt     = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_DONE;
               w_bcd_nxt   = {w_adj[BW-2:0], r_shift[WIDTH-1]};
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered outputs; busy/done mirror the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_bcd     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bcd     <= w_bcd_nxt;
         r_busy    <= (w_state_nxt == S_SHIFT);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq at WIDTH=8/DIGITS=3 and
// WIDTH=10/DIGITS=4. Expected results are queued at start and compared
// when done is observed.
module tb_bin_to_bcd_seq;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_fail;
   int   n_total;

   logic [15:0] q8[$];
   logic [15:0] q10[$];

   bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) u_if8 ();
   bin_to_bcd_seq_if #(.WIDTH(10), .DIGITS(4)) u_if10 ();

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (u_if8.slave)
   );

   bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut10 (
      .clk (clk),
      .rst (rst),
      .bus (u_if10.slave)
   );

   always #5 clk = ~clk;

   // Decimal reference: repeated division, independent of shift-and-add-3.
   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: pop and compare on every done, check busy/done exclusion.
   always @(negedge clk) begin
      if (!rst) begin
         check("excl8", {31'd0, u_if8.busy & u_if8.done}, 32'd0);
         check("excl10", {31'd0, u_if10.busy & u_if10.done}, 32'd0);
         if (u_if8.done) begin
            check("done8_expected", {31'd0, u_if8.done}, {31'd0, q8.size() != 0});
            if (q8.size() != 0) begin
               check("bcd8", {20'd0, u_if8.bcd}, {16'd0, q8.pop_front()});
            end
         end
         if (u_if10.done) begin
            check("done10_expected", {31'd0, u_if10.done}, {31'd0, q10.size() != 0});
            if (q10.size() != 0) begin
               check("bcd10", {16'd0, u_if10.bcd}, {16'd0, q10.pop_front()});
            end
         end
      end
   end

   // One conversion on the selected DUT; checks latency, busy span, done width, hold.
   task automatic run_conv(input int sel, input int v);
      int          w;
      int          lat;
      int          nbusy;
      logic        d;
      logic        b;
      logic [15:0] exp;
      w     = (sel != 0) ? 10 : 8;
      nbusy = 0;
      exp   = ref_bcd(v);
      if (sel != 0) begin
         u_if10.start = 1'b1;
         u_if10.bin   = 10'(v);
         q10.push_back(exp);
      end else begin
         u_if8.start  = 1'b1;
         u_if8.bin    = 8'(v);
         q8.push_back(exp);
      end
      tick();
      u_if8.start  = 1'b0;
      u_if10.start = 1'b0;
      for (lat = 1; lat < 40; lat++) begin
         d = (sel != 0) ? u_if10.done : u_if8.done;
         b = (sel != 0) ? u_if10.busy : u_if8.busy;
         if (d) break;
         if (b) nbusy++;
         tick();
      end
      check("latency", lat, w + 1);
      check("busy_cycles", nbusy, w);
      tick();
      d = (sel != 0) ? u_if10.done : u_if8.done;
      check("done_width", {31'd0, d}, 32'd0);
      if (sel != 0) begin
         check("bcd_hold10", {16'd0, u_if10.bcd}, {16'd0, exp});
      end else begin
         check("bcd_hold8", {20'd0, u_if8.bcd}, {16'd0, exp});
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      n_pass = 0;
      n_fail = 0;
      n_total = 0;
      u_if8.start  = 1'b0;
      u_if8.bin    = 8'd0;
      u_if10.start = 1'b0;
      u_if10.bin   = 10'd0;

      // Reset for two cycles, then idle quietly for 20 cycles.
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle8", {18'd0, u_if8.busy, u_if8.done, u_if8.bcd}, 32'd0);
         check("idle10", {14'd0, u_if10.busy, u_if10.done, u_if10.bcd}, 32'd0);
      end

      // Directed single conversions.
      run_conv(0, 0);
      run_conv(0, 255);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bcd_between", {20'd0, u_if8.bcd}, 32'h255);
      end
      run_conv(0, 99);
      run_conv(0, 100);

      // start held high: back-to-back conversions, bin changed mid-flight.
      u_if8.start = 1'b1;
      u_if8.bin   = 8'd37;
      q8.push_back(ref_bcd(37));
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc == 4)  u_if8.bin = 8'd200;
         if (cyc == 10) q8.push_back(ref_bcd(200));
         if (cyc == 19) u_if8.start = 1'b0;
         check("hold_done", {31'd0, u_if8.done}, {31'd0, (cyc == 9) || (cyc == 19)});
         tick();
      end
      check("hold_final_bcd", {20'd0, u_if8.bcd}, 32'h200);

      // Reset mid-conversion aborts it with no done pulse.
      u_if8.start = 1'b1;
      u_if8.bin   = 8'd173;
      tick();
      u_if8.start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("abort", {18'd0, u_if8.busy, u_if8.done, u_if8.bcd}, 32'd0);
         tick();
      end
      run_conv(0, 173);

      // Exhaustive sweeps.
      for (int v = 0; v < 256; v++) begin
         run_conv(0, v);
      end
      for (int v = 0; v < 1024; v++) begin
         run_conv(1, v);
      end
      check("bcd10_1023", {16'd0, u_if10.bcd}, 32'h1023);

      repeat (3) tick();
      check("q8_drained", q8.size(), 32'd0);
      check("q10_drained", q10.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that produces packed BCD digits for the BCD-to-Excess-3 code converter stage directly downstream. It accepts one unsigned binary word per start pulse and performs one shift per clock. After a fixed latency it presents all BCD digits at once with a one-cycle done strobe. Each 4-bit digit of `bcd` feeds one downstream Excess-3 converter instance unchanged.

## Interface
Parameters:
- `WIDTH`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD output digits.
  - Legal configurations satisfy 10^DIGITS > 2^WIDTH − 1.
  - No checking is required for illegal configurations.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a conversion; honoured only in IDLE.
- `bin`  in  WIDTH: unsigned binary operand, sampled only on an accepted start.
- `busy`  out  1: high while a conversion is in progress (SHIFT state).
- `done`  out  1: one-cycle pulse; `bcd` holds the new result in that cycle.
- `bcd`  out  4*DIGITS: packed BCD result.
  - Digit i occupies [4i+3:4i]; digit 0 is the units digit.
  - Every digit is always in the range 0–9 (valid BCD).

## Operation
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - On `start`=1: load `bin` into a WIDTH-bit shift register, clear the 4*DIGITS scratch register, set the iteration counter to WIDTH, then go to SHIFT.
  - On `start`=0: remain in IDLE.
- SHIFT, once per cycle:
  - Each scratch digit ≥ 5 gets +3, 4-bit result with no carry out.
  - Then shift {scratch, shift register} left by 1; the MSB of the shift register enters scratch bit 0.
  - Decrement the counter. After the WIDTH-th iteration, go to DONE.
- DONE:
  - Copy scratch to the `bcd` register.
  - Assert `done` for exactly this cycle, then return to IDLE.
- `start` in SHIFT or DONE is ignored; it is not queued.
- Changes on `bin` after acceptance have no effect on the conversion in flight.
- `bcd` holds its value until the next DONE or a reset. It never shows partial scratch values.
- Arithmetic widths:
  - Counter width is clog2(WIDTH+1).
  - Scratch never exceeds 4*DIGITS bits under the legal-configuration rule.
  - Bits shifted out of the top of scratch are discarded.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, shift register and scratch 0, counter 0.
- Reset has priority over `start` and over all state transitions in the same cycle.
- Reset during SHIFT or DONE:
  - The conversion is aborted and no `done` pulse follows.
  - `bcd` returns to 0 on the next clock edge.
- Cycle timeline, with cycle 0 being the cycle in which `start`=1 is sampled in IDLE:
  - Cycles 1..WIDTH: `busy`=1.
  - Cycle WIDTH+1: `busy`=0, `done`=1, `bcd` valid.
  - Cycle WIDTH+2: IDLE again; `start` is accepted here at the earliest.
- Latency: WIDTH+1 cycles from start sample to done. Maximum throughput: one conversion per WIDTH+2 cycles.
- If `start` is held high continuously, conversions repeat back-to-back with `done` every WIDTH+2 cycles. Each conversion samples `bin` in its own IDLE cycle.
- `busy` and `done` are never high together.
- All outputs are registered.

## Test plan
Defaults WIDTH=8, DIGITS=3 unless stated.
- Apply reset for 2 cycles, then release with `start`=0 -> `busy`=0, `done`=0, `bcd`=12'h000; all stay constant for 20 cycles.
- `bin`=8'd0 with a start pulse in cycle 0 -> `busy` high in cycles 1–8; `done`=1 only in cycle 9 with `bcd`=12'h000.
- Separate conversions:
  - `bin`=8'd255 -> `bcd`=12'h255.
  - `bin`=8'd99 -> `bcd`=12'h099.
  - `bin`=8'd100 -> `bcd`=12'h100.
  - Each result appears in the `done` cycle; `bcd` is unchanged between `done` pulses.
- Hold `start`=1 continuously, with `bin`=8'd37 at the first acceptance, `bin` changed to 8'd200 in cycle 4, and 8'd200 held thereafter:
  - First `done` in cycle 9 with `bcd`=12'h037.
  - Second acceptance in cycle 10; second `done` in cycle 19 with 12'h200.
  - `start` during `busy` causes no extra `done`.
- Start `bin`=8'd173, then assert `rst` in cycle 4 -> `busy`=0 and `bcd`=12'h000 from cycle 5; no `done` pulse occurs. A fresh start afterwards yields 12'h173 after 9 cycles.
- Exhaustive sweep of `bin`=0..255 with a reference model compare:
  - Every result is valid BCD matching the decimal value.
  - `done` width is exactly 1 cycle.
  - Latency is exactly 9 cycles.
  - Repeat the sweep at WIDTH=10, DIGITS=4 with `bin`=1023 -> `bcd`=16'h1023.
